regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Controller for the three-port register file's single write port (port 3) in the MIPS CPU. It shares the port between two write requesters, the pipeline writeback stage and the multicycle unit (mult/div, HI/LO moves, late loads), using a valid/ready handshake and round-robin fairness. It discards writes to $0. Optionally, it sequences a zero-clear sweep of every architectural register after reset or on request. It sits directly in front of `regfile`, and its outputs drive `addr_3_i`, `write_data_3_i` and `write_enable_i`.

## Interface
- `NUM_REGS`, 32, number of registers swept; addresses 1..NUM_REGS-1 are cleared.
- `ADDR_W`, 5, register address width; must hold NUM_REGS-1.
- `DATA_W`, 32, write data width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n_i`  in  1  reset, asynchronous and active-low.
- `req0_valid_i`  in  1  writeback stage has a write pending.
- `req0_addr_i`  in  ADDR_W  writeback destination register.
- `req0_data_i`  in  DATA_W  writeback data.
- `req0_ready_o`  out  1  writeback write accepted this cycle.
- `req1_valid_i`, `req1_addr_i`, `req1_data_i`, `req1_ready_o`: same as req0, for the multicycle unit.
- `clear_req_i`  in  1  request a clear sweep; single-cycle pulse.
- `rf_addr_3_o`  out  ADDR_W  to regfile `addr_3_i`.
- `rf_write_data_3_o`  out  DATA_W  to regfile `write_data_3_i`.
- `rf_write_enable_o`  out  1  to regfile `write_enable_i`.
- `busy_o`  out  1  clear sweep in progress; no requests are accepted.

## Operation
- State machine: CLEAR and RUN. Internal state is the sweep index `idx` and the round-robin pointer `rr` (0 = req0 favoured).
- Reset asserted:
  - State = CLEAR if the sweep is compiled in, else RUN.
  - `idx` = 1, `rr` = 0.
  - All outputs are forced low while `reset_n_i` is low: readies 0, write enable 0, address 0, data 0, `busy_o` 0.
- CLEAR:
  - Outputs: `rf_write_enable_o`=1, `rf_addr_3_o`=`idx`, data 0, `busy_o`=1, both readies 0.
  - Each cycle `idx` increments.
  - After the write to `idx`=NUM_REGS-1, the next state is RUN and `idx` returns to 1.
  - `clear_req_i` is ignored while in CLEAR.
- RUN, arbitration (ready depends combinationally on valid; a requester must never make valid depend on its own ready):
  - Only reqN valid: reqN ready.
  - Both valid: the requester selected by `rr` is ready; the other's ready is 0.
  - Neither valid: both readies 0, write enable 0.
- RUN, on a handshake (valid && ready):
  - The granted addr and data drive the rf outputs that cycle.
  - `rf_write_enable_o` = 1 unless the address is 0. A write to $0 is still accepted (ready=1) but not written.
  - `rr` is updated only when both requesters were valid: it points to the non-granted requester. A lone grant leaves `rr` unchanged.
- RUN, `clear_req_i`=1 (sweep compiled in):
  - Readies are 0 and write enable is 0 that cycle.
  - The next state is CLEAR with `idx`=1.
- An unaccepted request must hold its valid, addr and data stable until ready.
- Reset mid-sweep restarts the sweep from `idx`=1 after release.

## Timing
- Zero-latency accept: the handshake cycle's rising edge performs the regfile write. A read of that register returns the new value from the following cycle.
- Sweep length: NUM_REGS-1 cycles, which is 31 by default.
- First RUN cycle:
  - With the sweep: cycle 31 after reset release (cycles 0..30 are CLEAR).
  - Without the sweep: cycle 0.
- Worst-case wait with both requesters continuously valid: 1 cycle (strict alternation).
- `busy_o` is registered-state derived and glitch-free. Readies are combinational from the valids and state.

## Configuration
- `REGFILE_CLEAR_SWEEP_EN` defined:
  - CLEAR state, `idx` counter and `clear_req_i` handling are present.
  - Reset enters CLEAR.
- Not defined:
  - CLEAR logic is not built; state is RUN permanently.
  - `clear_req_i` is ignored, `busy_o` is tied 0.
  - Register contents after reset are whatever the regfile's own reset leaves.

## Test plan
- Reset release with the sweep in: `busy_o`=1 for exactly 31 cycles; addresses 1..31 written with 0 in order. Then req0 writes 0xDEADBEEF to $5 and a read of $5 returns 0xDEADBEEF.
- Lone requests: req0 valid to $3 ← 7, then req1 valid to $4 ← 9. Each is ready the same cycle, and $3=7, $4=9 afterwards.
- Contention: both valid for 4 cycles, req0 → $1 and req1 → $2 with changing data. Grants go req0, req1, req0, req1, and write enable is high every cycle.
- $0 discard: req1 writes 0x55 to $0. `req1_ready_o`=1, `rf_write_enable_o`=0, and $0 reads 0.
- `clear_req_i` pulse in RUN with req0 valid: req0 is not ready that cycle, `busy_o` rises next cycle, and after 31 cycles $1..$31 read 0. req0 is then accepted.
- Reset asserted at sweep cycle 10: outputs go low immediately; after release the sweep restarts at `idx`=1 and lasts 31 cycles. Without `REGFILE_CLEAR_SWEEP_EN`, `busy_o` stays 0 and req0 is accepted in cycle 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundle between the two regfile write requesters, the write-port
// arbiter and the regfile write port 3.
`timescale 1ns/1ps
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              req0_valid_i;
   logic [ADDR_W-1:0] req0_addr_i;
   logic [DATA_W-1:0] req0_data_i;
   logic              req0_ready_o;
   logic              req1_valid_i;
   logic [ADDR_W-1:0] req1_addr_i;
   logic [DATA_W-1:0] req1_data_i;
   logic              req1_ready_o;
   logic              clear_req_i;
   logic [ADDR_W-1:0] rf_addr_3_o;
   logic [DATA_W-1:0] rf_write_data_3_o;
   logic              rf_write_enable_o;
   logic              busy_o;

   modport master (
      output req0_valid_i, req0_addr_i, req0_data_i,
      output req1_valid_i, req1_addr_i, req1_data_i,
      output clear_req_i,
      input  req0_ready_o, req1_ready_o,
      input  rf_addr_3_o, rf_write_data_3_o, rf_write_enable_o, busy_o
   );

   modport slave (
      input  req0_valid_i, req0_addr_i, req0_data_i,
      input  req1_valid_i, req1_addr_i, req1_data_i,
      input  clear_req_i,
      output req0_ready_o, req1_ready_o,
      output rf_addr_3_o, rf_write_data_3_o, rf_write_enable_o, busy_o
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the regfile write port 3; drops writes to $0.
// Define REGFILE_CLEAR_SWEEP_EN to build the zero-clear sweep of $1..$NUM_REGS-1.
`timescale 1ns/1ps
module regfile_write_arbiter #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic                    clk,
   input  logic                    reset_n_i,
   regfile_write_arbiter_if.slave  bus
);

   typedef enum logic {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

`ifdef REGFILE_CLEAR_SWEEP_EN
   localparam state_t            RESET_STATE = ST_CLEAR;
   localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] idx_nx_s;
   logic              clear_s;
   assign clear_s = bus.clear_req_i;
`else
   localparam state_t RESET_STATE = ST_RUN;
   logic              clear_s;
   assign clear_s = 1'b0;
`endif

   state_t state_r;
   state_t state_nx_s;
   logic   rr_r;
   logic   rr_nx_s;
   logic   both_s;
   logic   grant0_s;
   logic   grant1_s;

   // rr_r = 1 favours req1 when both requesters contend.
   assign both_s   = bus.req0_valid_i & bus.req1_valid_i;
   assign grant0_s = bus.req0_valid_i & (~bus.req1_valid_i | ~rr_r);
   assign grant1_s = bus.req1_valid_i & (~bus.req0_valid_i | rr_r);

   // Next-state and port outputs; everything is held low while in reset.
   always_comb begin
      state_nx_s             = state_r;
      rr_nx_s                = rr_r;
`ifdef REGFILE_CLEAR_SWEEP_EN
      idx_nx_s               = idx_r;
`endif
      bus.req0_ready_o       = 1'b0;
      bus.req1_ready_o       = 1'b0;
      bus.rf_addr_3_o        = {ADDR_W{1'b0}};
      bus.rf_write_data_3_o  = {DATA_W{1'b0}};
      bus.rf_write_enable_o  = 1'b0;
      bus.busy_o             = 1'b0;
      if (!reset_n_i) begin
         state_nx_s = RESET_STATE;
         rr_nx_s    = 1'b0;
      end else begin
         case (state_r)
`ifdef REGFILE_CLEAR_SWEEP_EN
            ST_CLEAR: begin
               bus.rf_write_enable_o = 1'b1;
               bus.rf_addr_3_o       = idx_r;
               bus.busy_o            = 1'b1;
               if (idx_r == LAST_IDX) begin
                  state_nx_s = ST_RUN;
                  idx_nx_s   = ADDR_W'(1);
               end else begin
                  idx_nx_s   = idx_r + ADDR_W'(1);
               end
            end
`endif
            ST_RUN: begin
               if (clear_s) begin
                  state_nx_s = ST_CLEAR;
`ifdef REGFILE_CLEAR_SWEEP_EN
                  idx_nx_s   = ADDR_W'(1);
`endif
               end else if (grant0_s) begin
                  bus.req0_ready_o      = 1'b1;
                  bus.rf_addr_3_o       = bus.req0_addr_i;
                  bus.rf_write_data_3_o = bus.req0_data_i;
                  bus.rf_write_enable_o = (bus.req0_addr_i != {ADDR_W{1'b0}});
               end else if (grant1_s) begin
                  bus.req1_ready_o      = 1'b1;
                  bus.rf_addr_3_o       = bus.req1_addr_i;
                  bus.rf_write_data_3_o = bus.req1_data_i;
                  bus.rf_write_enable_o = (bus.req1_addr_i != {ADDR_W{1'b0}});
               end else begin
                  bus.rf_write_enable_o = 1'b0;
               end
               // Pointer moves to the loser only on real contention.
               if (both_s && !clear_s) begin
                  rr_nx_s = grant0_s;
               end else begin
                  rr_nx_s = rr_r;
               end
            end
            default: begin
               state_nx_s = RESET_STATE;
            end
         endcase
      end
   end

   // State, sweep index and round-robin pointer registers.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= RESET_STATE;
         rr_r    <= 1'b0;
`ifdef REGFILE_CLEAR_SWEEP_EN
         idx_r   <= ADDR_W'(1);
`endif
      end else begin
         state_r <= state_nx_s;
         rr_r    <= rr_nx_s;
`ifdef REGFILE_CLEAR_SWEEP_EN
         idx_r   <= idx_nx_s;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scoreboard bench for regfile_write_arbiter with a shadow regfile
// on the write port; covers both builds of REGFILE_CLEAR_SWEEP_EN.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic        r0;
      logic        r1;
      logic        we;
      logic        busy;
      logic [4:0]  addr;
      logic [31:0] data;
   } obs_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   obs_t        exp_q[$];
   string       tag_q[$];
   logic [31:0] shadow [32];
   logic [31:0] exp_rf [32];

   regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   regfile_write_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
      .clk       (clk),
      .reset_n_i (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Shadow of the regfile behind port 3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) shadow[i] <= 32'h0;
      end else if (bus.rf_write_enable_o) begin
         shadow[bus.rf_addr_3_o] <= bus.rf_write_data_3_o;
      end
   end

   function automatic obs_t mk(input logic r0, input logic r1, input logic we,
                               input logic busy, input logic [4:0] a, input logic [31:0] d);
      obs_t o;
      o = {r0, r1, we, busy, a, d};
      return o;
   endfunction

   task automatic step(input string tag,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic clr, input obs_t e);
      obs_t  o;
      obs_t  x;
      string t;
      bus.req0_valid_i = v0;
      bus.req0_addr_i  = a0;
      bus.req0_data_i  = d0;
      bus.req1_valid_i = v1;
      bus.req1_addr_i  = a1;
      bus.req1_data_i  = d1;
      bus.clear_req_i  = clr;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      o = {bus.req0_ready_o, bus.req1_ready_o, bus.rf_write_enable_o, bus.busy_o,
           bus.rf_addr_3_o, bus.rf_write_data_3_o};
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (o === x) else begin
         errors++;
         $error("FAIL %s: observed r0=%b r1=%b we=%b busy=%b addr=%0d data=%h, expected r0=%b r1=%b we=%b busy=%b addr=%0d data=%h",
                t, o.r0, o.r1, o.we, o.busy, o.addr, o.data, x.r0, x.r1, x.we, x.busy, x.addr, x.data);
      end
      @(posedge clk);
      #1;
      if (x.we) exp_rf[x.addr] = x.data;
   endtask

   task automatic chk_reg(input int i);
      checks++;
      assert (shadow[i] === exp_rf[i]) else begin
         errors++;
         $error("FAIL reg_%0d: observed %h, expected %h", i, shadow[i], exp_rf[i]);
      end
   endtask

`ifdef REGFILE_CLEAR_SWEEP_EN
   task automatic sweep(input string tag, input logic v0, input logic [4:0] a0,
                        input logic [31:0] d0, input int clr_at, input int ncyc);
      for (int i = 1; i <= ncyc; i++) begin
         step(tag, v0, a0, d0, 1'b0, 5'd0, 32'h0, (i == clr_at),
              mk(1'b0, 1'b0, 1'b1, 1'b1, 5'(i), 32'h0));
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clk    = 1'b0;
      rst_n  = 1'b0;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
      bus.req0_valid_i = 1'b0;
      bus.req0_addr_i  = 5'd0;
      bus.req0_data_i  = 32'h0;
      bus.req1_valid_i = 1'b0;
      bus.req1_addr_i  = 5'd0;
      bus.req1_data_i  = 32'h0;
      bus.clear_req_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      step("reset_outputs_low", 1'b1, 5'd3, 32'h7, 1'b1, 5'd4, 32'h9, 1'b1, '0);
      rst_n = 1'b1;
`ifdef REGFILE_CLEAR_SWEEP_EN
      sweep("boot_sweep", 1'b1, 5'd5, 32'hDEADBEEF, 5, 31);
`endif
      step("first_run_accept", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF));
      chk_reg(5);

      step("lone_req0", 1'b1, 5'd3, 32'h7, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'h7));
      step("lone_req1", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h9, 1'b0,
           mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 32'h9));
      chk_reg(3);
      chk_reg(4);

      step("contend_1", 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h21, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h11));
      step("contend_2", 1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h21, 1'b0,
           mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h21));
      step("contend_3", 1'b1, 5'd1, 32'h12, 1'b1, 5'd2, 32'h22, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h12));
      step("contend_4", 1'b1, 5'd1, 32'h13, 1'b1, 5'd2, 32'h22, 1'b0,
           mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h22));
      chk_reg(1);
      chk_reg(2);

      // A lone grant must not move the round-robin pointer.
      step("lone_req1_keeps_rr", 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0,
           mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'h66));
      step("contend_after_lone1", 1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h70));
      step("lone_req0_keeps_rr", 1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h90));
      step("contend_after_lone0", 1'b1, 5'd10, 32'hA0, 1'b1, 5'd8, 32'h80, 1'b0,
           mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h80));

      step("zero_discard", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55, 1'b0,
           mk(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55));
      chk_reg(0);
      step("contend_zero_addr", 1'b1, 5'd0, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0,
           mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hAA));
      step("contend_after_zero", 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hBB, 1'b0,
           mk(1'b0, 1'b1, 1'b1, 1'b0, 5'd11, 32'hBB));
      step("idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);

`ifdef REGFILE_CLEAR_SWEEP_EN
      step("clear_req_blocks", 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0, 1'b1, '0);
      sweep("clear_sweep", 1'b1, 5'd12, 32'hC0, 0, 31);
      for (int i = 0; i < 32; i++) chk_reg(i);
      step("after_clear_accept", 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 32'hC0));

      step("clear_req_again", 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'h0, 1'b1, '0);
      sweep("pre_reset_sweep", 1'b1, 5'd13, 32'hD0, 0, 10);
      rst_n = 1'b0;
      step("mid_sweep_reset", 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
      for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
      rst_n = 1'b1;
      sweep("restart_sweep", 1'b1, 5'd13, 32'hD0, 0, 31);
      step("after_restart_accept", 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'h0, 1'b0,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 32'hD0));
`else
      step("clear_req_ignored", 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0, 1'b1,
           mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 32'hC0));
      step("busy_stays_low", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, '0);
`endif

      for (int i = 0; i < 32; i++) chk_reg(i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
